// File: rtl/cmd_pkg.sv
// Shared definitions for the command deframer and the register decoder.
package cmd_pkg;

  localparam logic [7:0] HDR0_DEFAULT = 8'h55;
  localparam logic [7:0] HDR1_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_DATA,
    ST_CSUM
  } parse_state_e;

  // Command addresses understood by the downstream decoder.
  localparam logic [7:0] ADDR_ADC_RESTART  = 8'd0;
  localparam logic [7:0] ADDR_CHAN_SEL     = 8'd1;
  localparam logic [7:0] ADDR_SAMPLE_COUNT = 8'd2;
  localparam logic [7:0] ADDR_ADC_RATE     = 8'd3;
  localparam logic [7:0] ADDR_DDS_RESTART  = 8'd4;
  localparam logic [7:0] ADDR_WAVE_SEL     = 8'd5;
  localparam logic [7:0] ADDR_DDS_FTW      = 8'd6;

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle counter: clears on demand, counts up otherwise and
// holds at TIMEOUT_CYCLES-1, where it flags expiry.
module idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  // Count idle cycles, saturating at the expiry value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (count_q != LAST) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/cmd_frame_parser.sv
// Byte-stream command deframer: HDR0 HDR1 ADDR D3 D2 D1 D0 CSUM.
// Good frames pulse cmdvalid with addr/data; bad checksums and
// inter-byte stalls pulse frame_err and bump a saturating counter.
module cmd_frame_parser
  import cmd_pkg::*;
#(
  parameter logic [7:0]  HDR0           = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1           = HDR1_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmdvalid,
  output logic [7:0]  cmd_addr,
  output logic [31:0] cmd_data,
  output logic        frame_err,
  output logic [15:0] err_count
);

  parse_state_e state_q, state_d;

  logic [7:0]  sum_q;
  logic [1:0]  idx_q;
  logic [7:0]  addr_sh_q;
  logic [31:0] data_sh_q;

  logic load_addr;
  logic load_data;
  logic accept;
  logic reject;
  logic timeout;
  logic tmr_clear;
  logic tmr_expired;

  assign tmr_clear = rx_valid || (state_q == ST_IDLE);

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .expired(tmr_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; an arriving byte takes priority
  // over a timeout expiring in the same cycle.
  always_comb begin
    state_d   = state_q;
    load_addr = 1'b0;
    load_data = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    timeout   = tmr_expired && (state_q != ST_IDLE) && !rx_valid;
    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == HDR0) state_d = ST_HDR;
        end
        ST_HDR: begin
          if (rx_data == HDR1)      state_d = ST_ADDR;
          else if (rx_data == HDR0) state_d = ST_HDR;
          else                      state_d = ST_IDLE;
        end
        ST_ADDR: begin
          load_addr = 1'b1;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          load_data = 1'b1;
          if (idx_q == 2'd3) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_data == sum_q) accept = 1'b1;
          else                  reject = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
    end
  end

  // Shadow registers, running sum, outputs and error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q     <= '0;
      idx_q     <= '0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      cmdvalid  <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      cmdvalid  <= 1'b0;
      frame_err <= 1'b0;
      if (load_addr) begin
        addr_sh_q <= rx_data;
        sum_q     <= rx_data;
        idx_q     <= '0;
      end
      if (load_data) begin
        data_sh_q <= {data_sh_q[23:0], rx_data};
        sum_q     <= sum_q + rx_data;
        idx_q     <= idx_q + 2'd1;
      end
      if (accept) begin
        cmd_addr <= addr_sh_q;
        cmd_data <= data_sh_q;
        cmdvalid <= 1'b1;
      end
      if (reject || timeout) begin
        frame_err <= 1'b1;
        if (err_count != '1) err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Scoreboard bench for cmd_frame_parser: a byte-level reference model
// queues expected output events, a negedge monitor checks them.
module tb_cmd_frame_parser;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmdvalid;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        frame_err;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  cmd_frame_parser #(
    .HDR0          (8'h55),
    .HDR1          (8'hA5),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .cmdvalid (cmdvalid),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .frame_err(frame_err),
    .err_count(err_count)
  );

  typedef struct {
    bit          err;
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
    int          ecnt;
  } ev_t;

  ev_t exq[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: pos = bytes of the current frame seen so far
  // (0 = hunting for HDR0), fb holds ADDR D3 D2 D1 D0 CSUM.
  int          pos;
  logic [7:0]  fb[6];
  int          last_c;
  int          m_ecnt;
  logic [7:0]  m_addr;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    pos    = 0;
    last_c = 0;
    m_ecnt = 0;
    m_addr = 8'h00;
    m_data = 32'h0;
  endfunction

  function automatic void push_err(int c);
    ev_t e;
    if (m_ecnt < 65535) m_ecnt = m_ecnt + 1;
    e.err = 1; e.cyc = c; e.addr = m_addr; e.data = m_data; e.ecnt = m_ecnt;
    exq.push_back(e);
  endfunction

  function automatic void model_byte(logic [7:0] b, int c);
    ev_t e;
    int  s;
    last_c = c;
    if (pos == 0) begin
      if (b == 8'h55) pos = 1;
    end else if (pos == 1) begin
      pos = (b == 8'hA5) ? 2 : ((b == 8'h55) ? 1 : 0);
    end else begin
      fb[pos-2] = b;
      pos++;
      if (pos == 8) begin
        s = (int'(fb[0]) + int'(fb[1]) + int'(fb[2]) + int'(fb[3]) + int'(fb[4])) % 256;
        if (int'(fb[5]) == s) begin
          m_addr = fb[0];
          m_data = {fb[1], fb[2], fb[3], fb[4]};
          e.err = 0; e.cyc = c + 1; e.addr = m_addr; e.data = m_data; e.ecnt = m_ecnt;
          exq.push_back(e);
        end else begin
          push_err(c + 1);
        end
        pos = 0;
      end
    end
  endfunction

  // A stall of exactly T cycles after the last byte expires mid-frame.
  function automatic void model_tick(int c);
    if (pos > 0 && c - last_c == T) begin
      push_err(c + 1);
      pos = 0;
    end
  endfunction

  task automatic idle_cyc();
    rx_valid = 1'b0;
    model_tick(cyc);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    model_byte(b, cyc);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    repeat (gap - 1) idle_cyc();
    send_byte(b);
  endtask

  task automatic put_list(input logic [7:0] bl[$]);
    foreach (bl[i]) put(bl[i], 1);
  endtask

  function automatic int rnd_gap();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 1;
  endfunction

  // Frame with optional corrupt checksum, optional stall before byte
  // stall_at, and optional truncation to the first n_bytes bytes.
  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input bit bad,
                            input int stall_at, input int stall_gap, input int n_bytes);
    logic [7:0] b[8];
    logic [7:0] cs;
    cs = a + d[31:24] + d[23:16] + d[15:8] + d[7:0];
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    b[0] = 8'h55; b[1] = 8'hA5; b[2] = a;
    b[3] = d[31:24]; b[4] = d[23:16]; b[5] = d[15:8]; b[6] = d[7:0]; b[7] = cs;
    for (int i = 0; i < n_bytes; i++)
      put(b[i], (i == stall_at) ? stall_gap : rnd_gap());
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("rst_cmdvalid", 32'(cmdvalid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_cmd_addr", 32'(cmd_addr), 32'h0);
    chk("rst_cmd_data", cmd_data, 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
  endtask

  // Monitor: every output pulse must match the next queued event.
  always @(negedge clk) begin
    if (!reset && (cmdvalid || frame_err)) begin
      ev_t e;
      chk("pulse_exclusive", 32'(cmdvalid & frame_err), 32'h0);
      if (exq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got cmdvalid=%b frame_err=%b expected none (cyc=%0d)",
                 cmdvalid, frame_err, cyc);
      end else begin
        e = exq.pop_front();
        chk("pulse_kind", 32'(frame_err), 32'(e.err));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("cmd_addr", 32'(cmd_addr), 32'(e.addr));
        chk("cmd_data", cmd_data, e.data);
        chk("err_count", 32'(err_count), 32'(e.ecnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_data = 8'h00;
    do_reset();

    // Directed cases.
    put_list('{8'h55, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h03});
    repeat (3) idle_cyc();
    put_list('{8'h55, 8'hA5, 8'h06, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00});
    repeat (3) idle_cyc();
    put_list('{8'h55, 8'h55, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h10});
    repeat (3) idle_cyc();
    put_list('{8'h55, 8'hA5, 8'h03});
    repeat (20) idle_cyc();
    put_list('{8'h55, 8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h2A, 8'h2D});
    send_frame(8'h04, 32'hCAFE0001, 1'b0, 4, T, 8);
    send_frame(8'h04, 32'hCAFE0002, 1'b0, 4, T + 1, 8);
    send_frame(8'h07, 32'h55A555A5, 1'b0, 7, T - 1, 8);
    put_list('{8'h55, 8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8'h07,
               8'h55, 8'hA5, 8'h06, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07});
    repeat (3) idle_cyc();
    put_list('{8'h55, 8'hA5, 8'h02, 8'h00});
    do_reset();
    put_list('{8'h00, 8'h01, 8'h00, 8'h03});
    repeat (3) idle_cyc();
    put_list('{8'h55, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h03});

    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      int          k;
      logic [7:0]  a;
      logic [31:0] d;
      k = int'($urandom_range(0, 9));
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      if (k <= 4) begin
        send_frame(a, d, 1'b0, -1, 1, 8);
      end else if (k <= 6) begin
        send_frame(a, d, 1'b1, -1, 1, 8);
      end else if (k == 7) begin
        int nj;
        nj = int'($urandom_range(1, 4));
        for (int j = 0; j < nj; j++)
          put(($urandom_range(0, 2) == 0) ? 8'h55 : 8'($urandom_range(0, 255)), rnd_gap());
      end else if (k == 8) begin
        send_frame(a, d, 1'b0, -1, 1, int'($urandom_range(1, 7)));
        repeat (T + int'($urandom_range(0, 3))) idle_cyc();
      end else begin
        send_frame(a, d, 1'b0, int'($urandom_range(1, 7)),
                   T - 1 + int'($urandom_range(0, 2)), 8);
      end
    end

    repeat (T + 5) idle_cyc();
    chk("queue_drained", 32'(exq.size()), 32'h0);
    chk("final_err_count", 32'(err_count), 32'(m_ecnt));
    chk("final_cmd_addr", 32'(cmd_addr), 32'(m_addr));
    chk("final_cmd_data", cmd_data, m_data);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Byte-stream command deframer that sits directly upstream of the command register decoder. It consumes bytes from the UART receiver and assembles framed commands. It validates each frame with a header and an 8-bit checksum. For each good frame it emits a single-cycle `cmdvalid` pulse with an 8-bit address and a 32-bit data word, which the decoder latches into the ADC/DDS control registers. Malformed or stalled frames are discarded and counted.

## Interface
Parameters:
- `HDR0`, default 8'h55: first header byte.
- `HDR1`, default 8'hA5: second header byte.
- `TIMEOUT_CYCLES`, default 500000: inter-byte idle limit in `clk` cycles (10 ms at 50 MHz). Minimum 2.

Ports:
- `clk`  in  1: system clock. One clock domain only.
- `reset`  in  1: synchronous, active-high reset.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid this cycle. Strobes may arrive on consecutive cycles.
- `rx_data`  in  8: received byte.
- `cmdvalid`  out  1: one-cycle pulse for each accepted frame.
- `cmd_addr`  out  8: address of the last accepted frame. Holds its value between frames.
- `cmd_data`  out  32: data of the last accepted frame. Holds its value between frames.
- `frame_err`  out  1: one-cycle pulse on a checksum mismatch or a timeout.
- `err_count`  out  16: count of `frame_err` pulses. Saturates at 16'hFFFF.

## Operation
- Frame format is 8 bytes: `HDR0`, `HDR1`, ADDR, D3 (MSB), D2, D1, D0, CSUM.
- CSUM = (ADDR + D3 + D2 + D1 + D0) mod 256.
- States are IDLE, HDR, ADDR, DATA, CSUM. A 2-bit byte index selects D3..D0 while in DATA.
- Transitions happen only in cycles where `rx_valid` = 1:
  - IDLE: byte = `HDR0` → HDR; any other byte → stay in IDLE.
  - HDR: byte = `HDR1` → ADDR; byte = `HDR0` → stay in HDR (resync); any other byte → IDLE.
  - ADDR: latch the byte into a shadow address register, start the running sum with it → DATA, index 0.
  - DATA: shift the byte into the 32-bit shadow data register MSB-first and add it to the running sum. After the 4th data byte → CSUM.
  - CSUM, byte = sum: copy the shadow registers to `cmd_addr`/`cmd_data`, pulse `cmdvalid` → IDLE.
  - CSUM, byte ≠ sum: pulse `frame_err`, increment `err_count` → IDLE. Outputs are not updated.
- Header bytes inside the payload carry no special meaning; they are treated as plain data.
- Timeout:
  - An idle counter clears on every `rx_valid` and in IDLE.
  - Otherwise it increments each cycle.
  - When it reaches `TIMEOUT_CYCLES`-1 in any non-IDLE state, the block pulses `frame_err`, increments `err_count`, and returns to IDLE.
- If a byte arrives in the same cycle the timeout would fire, the byte wins: it is processed normally and no error is raised.
- Address and data are forwarded unchanged. Address values the decoder does not recognise are still emitted.

## Timing
- Reset values:
  - State IDLE; sum, index and idle counter 0.
  - `cmdvalid` 0, `cmd_addr` 8'h00, `cmd_data` 32'h0.
  - `frame_err` 0, `err_count` 0.
- Latency: `cmdvalid`, `cmd_addr` and `cmd_data` update on the clock edge after the cycle in which CSUM is presented. `cmd_addr`/`cmd_data` are valid in the same cycle `cmdvalid` is high.
- `frame_err` follows the same 1-cycle latency from the offending byte, or from the expiry cycle.
- Back-to-back frames with `rx_valid` high every cycle are supported. A new frame's `HDR0` may arrive on the cycle right after the previous CSUM.
- There is no backpressure. The downstream decoder must accept a `cmdvalid` pulse in any cycle.
- Reset asserted mid-frame discards the partial frame. The first byte after reset is parsed from IDLE.
- `cmdvalid` and `frame_err` are never high in the same cycle.

## Structure
- Shared package `cmd_pkg` holds:
  - the default `HDR0`/`HDR1` values,
  - the frame length constant (8),
  - the parser state enum,
  - the command address constants used by the decoder (0 restart ADC, 1 channel select, 2 sample count, 3 ADC rate, 4 restart DDS, 5 waveform select, 6 DDS FTW).
- One sub-module is natural: `idle_timer`, a loadable counter with clear and expiry flag, parameterised by `TIMEOUT_CYCLES`. Everything else stays in the parser.

## Test plan
- Good frame: bytes 55 A5 02 00 00 01 00 03 → exactly one `cmdvalid` pulse, `cmd_addr`=8'h02, `cmd_data`=32'h00000100, `frame_err` stays 0.
- Bad checksum: bytes 55 A5 06 12 34 56 78 00 → no `cmdvalid`, one `frame_err` pulse, `err_count`=1, `cmd_data` keeps its previous value.
- Resync: bytes 55 55 A5 01 00 00 00 0F 10 → `cmdvalid` with `cmd_addr`=8'h01 and `cmd_data`=32'h0000000F.
- Timeout: with `TIMEOUT_CYCLES`=16, send 55 A5 03 then wait 20 cycles → one `frame_err` and parser back in IDLE. A following full valid frame is accepted. Repeat with a byte landing exactly on cycle 15: no error.
- Back-to-back: two valid frames (addr 05 data 00000002 csum 07; addr 06 data 01000000 csum 07) with `rx_valid` high every cycle → two `cmdvalid` pulses 8 cycles apart with the correct values.
- Reset mid-frame: assert `reset` after 55 A5 02 00 → all outputs return to their reset values. The remaining bytes 00 01 00 03 produce nothing; a fresh full frame is then accepted.
